trace_capture_fifo: RTL
=======================

TRACE_CAPTURE_FIFO -- requirements
Module: trace_capture_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..64).
REQ-002 The module SHALL have parameter DATA_W, default 16, meaning captured data width.
REQ-003 The module SHALL have parameter TS_W, default 32, meaning timestamp counter width.
REQ-004 The module SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 The module SHALL have port reset  input  1  synchronous, active-low reset: reset=0 at a rising clk edge resets; reset=1 is normal operation.
REQ-006 The module SHALL have port io_in_valid  input  1  capture request for io_in_bits this cycle.
REQ-007 The module SHALL have port io_in_bits  input  DATA_W  sample to capture (upstream {x,y} word).
REQ-008 The module SHALL have port io_out_valid  output  1  head entry available.
REQ-009 The module SHALL have port io_out_ready  input  1  consumer accepts head entry.
REQ-010 The module SHALL have port io_out_bits  output  TS_W+DATA_W  head entry {timestamp, data}, timestamp in MSBs.
REQ-011 The module SHALL have port io_count  output  log2(DEPTH)+1  current occupancy.
REQ-012 The module SHALL have port io_overflow  output  1  sticky flag, a capture was dropped.
REQ-013 The module SHALL have port io_drop_count  output  8  saturating count of dropped captures.
REQ-014 The module SHALL have port io_clear  input  1  clears io_overflow and io_drop_count.

Function
REQ-015 Timestamp counter tsc SHALL be 0 in the first cycle after reset release, increment by 1 every non-reset cycle, and wrap from 2^TS_W-1 to 0.
REQ-016 A capture SHALL store {tsc value of the capture cycle, io_in_bits} at the tail.
REQ-017 Push SHALL occur when io_in_valid=1 and (count<DEPTH or pop occurs the same cycle).
REQ-018 Pop SHALL occur when io_out_valid=1 and io_out_ready=1.
REQ-019 io_out_valid SHALL equal (count!=0); io_out_bits SHALL be the oldest entry, stable while io_out_valid=1 and no pop occurs.
REQ-020 No combinational bypass: an entry pushed in cycle N SHALL first appear on io_out_bits in cycle N+1 at the earliest.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including when count=DEPTH and when count=1.
REQ-022 io_in_valid=1 while count=DEPTH with no pop SHALL drop the sample, set io_overflow, and increment io_drop_count, saturating at 255.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO across wrap.
REQ-024 io_clear=1 SHALL zero io_overflow and io_drop_count next cycle; a drop in the same cycle SHALL win, yielding io_overflow=1, io_drop_count=1.
REQ-025 io_clear SHALL NOT affect FIFO contents, count, or tsc.
REQ-026 io_out_ready with count=0 SHALL have no effect; io_count SHALL never exceed DEPTH nor underflow.

Reset
REQ-027 While reset=0, at each rising edge: tsc=0, pointers=0, io_count=0, io_out_valid=0, io_overflow=0, io_drop_count=0; io_in_valid ignored.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries at that edge; io_out_bits is don't-care while io_out_valid=0.
REQ-029 Storage array contents SHALL NOT require reset.

Verification
REQ-030 Reset release, io_in_valid=1 with io_in_bits=0xAB12 in the first cycle, io_out_ready=0 -> next cycle io_out_valid=1, io_out_bits=0x00000000_AB12, io_count=1.
REQ-031 Push 8 samples on consecutive cycles 0x0001..0x0008, ready=0, then a 9th 0x0009 -> io_count=8, io_overflow=1, io_drop_count=1; draining yields 0x0001..0x0008 in order with timestamps 0..7.
REQ-032 Full FIFO with io_in_valid=1 and io_out_ready=1 in the same cycle -> head popped, new sample accepted, io_count stays 8, no drop recorded.
REQ-033 300 dropped captures -> io_drop_count=255; io_clear with no drop -> 0 and io_overflow=0; io_clear together with a drop -> io_drop_count=1, io_overflow=1.
REQ-034 Continuous push and pop for 20 cycles with DEPTH=8 -> pointers wrap twice, output data equals input data delayed by exactly 1 cycle, io_count=1 throughout.
REQ-035 Reset=0 for one cycle with io_count=5 -> next cycle io_count=0, io_out_valid=0, tsc restarts at 0.

Source files
------------

// File: rtl/trace_capture_fifo.sv
// Timestamped trace capture FIFO: tags each accepted sample with a free-running
// cycle counter and records dropped captures in a sticky flag and saturating count.
module trace_capture_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int TS_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       io_in_valid,
    input  logic [DATA_W-1:0]          io_in_bits,
    output logic                       io_out_valid,
    input  logic                       io_out_ready,
    output logic [TS_W+DATA_W-1:0]     io_out_bits,
    output logic [$clog2(DEPTH):0]     io_count,
    output logic                       io_overflow,
    output logic [7:0]                 io_drop_count,
    input  logic                       io_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TS_W + DATA_W;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic [TS_W-1:0] tsc_q, tsc_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drop_q, drop_d;

    logic push, pop, drop;

    assign pop  = (count_q != '0) && io_out_ready;
    assign push = io_in_valid && ((count_q != FULL) || pop);
    assign drop = io_in_valid && !push;

    always_comb begin
        tsc_d   = tsc_q + TS_W'(1);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear restarts the tally at one.
        if (io_clear) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = io_clear ? 8'd1 :
                     (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tsc_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            tsc_q   <= tsc_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (reset && push) mem_q[wptr_q] <= {tsc_q, io_in_bits};
    end

    assign io_out_valid  = (count_q != '0);
    assign io_out_bits   = mem_q[rptr_q];
    assign io_count      = count_q;
    assign io_overflow   = ovf_q;
    assign io_drop_count = drop_q;

endmodule
